// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: the instruction-memory request/response channel and
// the decode-side instruction channel. The master side belongs to the fetch
// unit; the slave side is the memory/decode environment.
interface fetch_unit_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) ();
  logic                     imem_req_valid;
  logic                     imem_req_ready;
  logic [ADDRESS_WIDTH-1:0] imem_req_addr;
  logic                     imem_rsp_valid;
  logic [DATA_WIDTH-1:0]    imem_rsp_data;
  logic                     inst_valid;
  logic                     inst_ready;
  logic [DATA_WIDTH-1:0]    inst_data;
  logic [ADDRESS_WIDTH-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Issues sequential word reads, tags each returned
// word with its PC in a small in-order FIFO, and on a redirect flushes the
// FIFO and silently drops responses still in flight from the old path.
// Requests are only issued while the FIFO has room for every response that
// could come back, so memory responses never need backpressure.
module fetch_unit #(
  parameter int                    ADDRESS_WIDTH = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    FIFO_DEPTH    = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trigger,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  fetch_unit_if.master             bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]         DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(3'd4);

  logic [ADDRESS_WIDTH-1:0] fetch_pc_r;
  logic [ADDRESS_WIDTH-1:0] rsp_pc_r;
  logic [CNT_W-1:0]         outstanding_r;
  logic [CNT_W-1:0]         drop_cnt_r;
  logic [CNT_W-1:0]         count_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [DATA_WIDTH-1:0]    data_mem_r [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_mem_r   [FIFO_DEPTH];

  logic [CNT_W:0]           inflight_s;
  logic                     credit_ok_s;
  logic                     req_valid_s;
  logic                     req_fire_s;
  logic                     fifo_valid_s;
  logic                     pop_s;
  logic                     drop_s;
  logic                     push_s;
  logic [ADDRESS_WIDTH-1:0] target_s;

  // Handshake decode: credit check, fire/push/pop/drop qualifiers.
  always_comb begin
    inflight_s   = {1'b0, count_r} + {1'b0, outstanding_r};
    credit_ok_s  = (inflight_s < DEPTH_EXT);
    req_valid_s  = trigger & ~redirect & credit_ok_s;
    req_fire_s   = req_valid_s & bus.imem_req_ready;
    fifo_valid_s = (count_r != {CNT_W{1'b0}});
    pop_s        = fifo_valid_s & bus.inst_ready;
    drop_s       = bus.imem_rsp_valid & (drop_cnt_r != {CNT_W{1'b0}});
    push_s       = bus.imem_rsp_valid & (drop_cnt_r == {CNT_W{1'b0}});
    target_s     = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
  end

  // Bus outputs: request mirrors the fetch PC; head fields read zero when empty.
  always_comb begin
    bus.imem_req_valid = req_valid_s;
    bus.imem_req_addr  = fetch_pc_r;
    bus.inst_valid     = fifo_valid_s;
    if (fifo_valid_s) begin
      bus.inst_data = data_mem_r[rd_ptr_r];
      bus.inst_pc   = pc_mem_r[rd_ptr_r];
    end else begin
      bus.inst_data = {DATA_WIDTH{1'b0}};
      bus.inst_pc   = {ADDRESS_WIDTH{1'b0}};
    end
  end

  // Control state: PCs, in-flight/stale counters, FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r    <= RESET_VECTOR;
      rsp_pc_r      <= RESET_VECTOR;
      outstanding_r <= {CNT_W{1'b0}};
      drop_cnt_r    <= {CNT_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      wr_ptr_r      <= {PTR_W{1'b0}};
    end else if (redirect) begin
      // Everything still in flight belongs to the old path; a response landing
      // this very cycle is already accounted for and is simply thrown away.
      fetch_pc_r    <= target_s;
      rsp_pc_r      <= target_s;
      outstanding_r <= outstanding_r - CNT_W'(bus.imem_rsp_valid);
      drop_cnt_r    <= outstanding_r - CNT_W'(bus.imem_rsp_valid);
      count_r       <= {CNT_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      wr_ptr_r      <= {PTR_W{1'b0}};
    end else begin
      if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end
      outstanding_r <= outstanding_r + CNT_W'(req_fire_s) - CNT_W'(bus.imem_rsp_valid);
      if (drop_s) begin
        drop_cnt_r <= drop_cnt_r - CNT_W'(1'b1);
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
        rsp_pc_r <= rsp_pc_r + PC_STEP;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // FIFO storage: write the kept response together with its PC tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_r[i] <= {DATA_WIDTH{1'b0}};
        pc_mem_r[i]   <= {ADDRESS_WIDTH{1'b0}};
      end
    end else if (push_s && !redirect) begin
      data_mem_r[wr_ptr_r] <= bus.imem_rsp_data;
      pc_mem_r[wr_ptr_r]   <= rsp_pc_r;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A behavioural memory returns
// addr-derived words after a programmable latency; the reference model says
// that decode must see exactly the requests accepted since the last redirect,
// in order, and that requests are issued only when every in-flight response
// plus every buffered instruction still fits in the FIFO.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        trigger;
  logic        redirect;
  logic [31:0] redirect_pc;

  fetch_unit_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  fetch_unit #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(32),
    .FIFO_DEPTH(DEPTH),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .trigger(trigger),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] popped_pc_q[$];
  int          cyc;
  int          occ_m;
  int          epoch;
  int          lat;
  int          last_due;
  logic [31:0] model_pc;
  logic [31:0] salt;
  int          fire_cnt;
  int          pop_cnt;
  int          checks;
  int          failures;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ salt;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic step(input logic trig, input logic mrdy, input logic irdy,
                      input logic redir, input logic [31:0] rpc);
    logic        rsp_now;
    int          rsp_ep;
    logic        exp_rv;
    logic        exp_iv;
    logic [31:0] exp_pc;
    logic [31:0] exp_data;
    logic        fire;
    logic        pop;
    int          due;
    trigger            = trig;
    bus.imem_req_ready = mrdy;
    bus.inst_ready     = irdy;
    redirect           = redir;
    redirect_pc        = rpc;
    rsp_now            = (pend.size() > 0) && (pend[0].due <= cyc);
    rsp_ep             = rsp_now ? pend[0].epoch : -1;
    bus.imem_rsp_valid = rsp_now;
    bus.imem_rsp_data  = rsp_now ? mem_word(pend[0].addr) : 32'd0;
    #1;
    exp_rv = trig && !redir && ((occ_m + pend.size()) < DEPTH);
    checks++;
    if (bus.imem_req_valid !== exp_rv) begin
      failures++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, bus.imem_req_valid, exp_rv);
    end
    if (exp_rv) begin
      checks++;
      if (bus.imem_req_addr !== model_pc) begin
        failures++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_req_addr, model_pc);
      end
    end
    exp_iv   = (occ_m != 0);
    exp_pc   = exp_iv ? exp_q[0] : 32'd0;
    exp_data = exp_iv ? mem_word(exp_q[0]) : 32'd0;
    checks++;
    if (bus.inst_valid !== exp_iv) begin
      failures++;
      $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, bus.inst_valid, exp_iv);
    end
    checks++;
    if (bus.inst_pc !== exp_pc) begin
      failures++;
      $display("FAIL inst_pc cyc=%0d got=%h exp=%h", cyc, bus.inst_pc, exp_pc);
    end
    checks++;
    if (bus.inst_data !== exp_data) begin
      failures++;
      $display("FAIL inst_data cyc=%0d got=%h exp=%h", cyc, bus.inst_data, exp_data);
    end
    fire = bus.imem_req_valid && mrdy;
    pop  = exp_iv && irdy;
    if (bus.inst_valid && irdy && !redir) popped_pc_q.push_back(bus.inst_pc);
    if (rsp_now) void'(pend.pop_front());
    if (redir) begin
      epoch++;
      exp_q.delete();
      occ_m    = 0;
      model_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        occ_m--;
        pop_cnt++;
      end
      if (rsp_now && rsp_ep == epoch) occ_m++;
      if (fire) begin
        exp_q.push_back(model_pc);
        model_pc = model_pc + 32'd4;
      end
    end
    if (fire) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: bus.imem_req_addr, due: due, epoch: epoch});
      fire_cnt++;
    end
    @(negedge clk);
    cyc++;
  endtask

  // Asynchronous reset (memory is reset alongside), checking reset outputs.
  task automatic do_reset();
    rst_n              = 1'b0;
    trigger            = 1'b0;
    redirect           = 1'b0;
    redirect_pc        = 32'd0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    bus.inst_ready     = 1'b0;
    #1;
    checks++;
    if (bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_req got=%b/%h exp=0/00000000", bus.imem_req_valid, bus.imem_req_addr);
    end
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.inst_data !== 32'd0 || bus.inst_pc !== 32'd0) begin
      failures++;
      $display("FAIL reset_inst got=%b/%h/%h exp=0/0/0", bus.inst_valid, bus.inst_data, bus.inst_pc);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    pend.delete();
    exp_q.delete();
    popped_pc_q.delete();
    occ_m    = 0;
    epoch++;
    model_pc = 32'h0;
    last_due = -1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_sequential();
    int p0;
    do_reset();
    lat = 1;
    p0  = pop_cnt;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    checks++;
    if (pop_cnt - p0 != 18) begin
      failures++;
      $display("FAIL seq_throughput got=%0d exp=18", pop_cnt - p0);
    end
    checks++;
    if (popped_pc_q.size() < 3 || popped_pc_q[2] !== 32'h8) begin
      failures++;
      $display("FAIL seq_third_pc got=%h exp=00000008", popped_pc_q.size() >= 3 ? popped_pc_q[2] : 32'hx);
    end
  endtask

  task automatic test_backpressure();
    int f0;
    do_reset();
    lat = 1;
    f0  = fire_cnt;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    checks++;
    if (fire_cnt - f0 != DEPTH) begin
      failures++;
      $display("FAIL bp_accepted got=%0d exp=%0d", fire_cnt - f0, DEPTH);
    end
    f0 = fire_cnt;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    checks++;
    if (popped_pc_q.size() < 4 || popped_pc_q[3] !== 32'hC) begin
      failures++;
      $display("FAIL bp_drain got=%0d entries exp>=4 ending 0000000c", popped_pc_q.size());
    end
    checks++;
    if (fire_cnt == f0) begin
      failures++;
      $display("FAIL bp_resume got=0 new requests exp>0");
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    lat = 3;
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h103);
    popped_pc_q.delete();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    checks++;
    if (popped_pc_q.size() == 0 || popped_pc_q[0] !== 32'h100) begin
      failures++;
      $display("FAIL redir_first_pc got=%h exp=00000100", popped_pc_q.size() > 0 ? popped_pc_q[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_collision();
    logic found;
    do_reset();
    lat   = 2;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (occ_m == 2 && pend.size() > 0 && pend[0].due <= cyc) found = 1'b1;
      else step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL collide_setup got=not_reached exp=occupancy2_with_response");
    end else begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
      popped_pc_q.delete();
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
      checks++;
      if (popped_pc_q.size() == 0 || popped_pc_q[0] !== 32'h200) begin
        failures++;
        $display("FAIL collide_first_pc got=%h exp=00000200", popped_pc_q.size() > 0 ? popped_pc_q[0] : 32'hx);
      end
    end
  endtask

  task automatic test_trigger_low();
    int f0;
    int p0;
    do_reset();
    lat = 3;
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    f0 = fire_cnt;
    p0 = pop_cnt;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    checks++;
    if (fire_cnt != f0) begin
      failures++;
      $display("FAIL trig_low_requests got=%0d exp=0", fire_cnt - f0);
    end
    checks++;
    if (pop_cnt - p0 != 2) begin
      failures++;
      $display("FAIL trig_low_delivered got=%0d exp=2", pop_cnt - p0);
    end
    popped_pc_q.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    checks++;
    if (popped_pc_q.size() == 0 || popped_pc_q[0] !== 32'h8) begin
      failures++;
      $display("FAIL trig_resume_pc got=%h exp=00000008", popped_pc_q.size() > 0 ? popped_pc_q[0] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want [5];
    do_reset();
    lat = 1;
    want[0] = 32'hFFFF_FFF4;
    want[1] = 32'hFFFF_FFF8;
    want[2] = 32'hFFFF_FFFC;
    want[3] = 32'h0000_0000;
    want[4] = 32'h0000_0004;
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF7);
    popped_pc_q.delete();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (popped_pc_q.size() <= i || popped_pc_q[i] !== want[i]) begin
        failures++;
        $display("FAIL wrap_pc[%0d] got=%h exp=%h", i, popped_pc_q.size() > i ? popped_pc_q[i] : 32'hx, want[i]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      lat = int'($urandom_range(1, 3));
      step(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
           ($urandom % 16) == 0, $urandom);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 2;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, ($urandom % 2) == 0, 1'b0, 32'd0);
    do_reset();
    lat = 1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    checks++;
    if (popped_pc_q.size() == 0 || popped_pc_q[0] !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_first_pc got=%h exp=00000000", popped_pc_q.size() > 0 ? popped_pc_q[0] : 32'hx);
    end
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    cyc      = 0;
    occ_m    = 0;
    epoch    = 0;
    lat      = 1;
    last_due = -1;
    model_pc = 32'h0;
    fire_cnt = 0;
    pop_cnt  = 0;
    checks   = 0;
    failures = 0;
    salt     = $urandom;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drop();
    test_redirect_collision();
    test_trigger_low();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
